button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Upstream conditioning stage for the push-button counter: converts a raw, bouncing, asynchronous push-button into clean single-cycle event pulses in the system clock domain.
- The downstream 2-bit counter consumes btn_press instead of the raw pin.
- Also provides a debounced level and a one-shot long-press event.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a press or release (10 ms at 100 MHz); legal range is 1 or more.
- HOLD_CYCLES, 100000000, cycles spent in PRESSED before btn_long fires; legal range is 1 or more.
- CNT_W, 27, width of both internal counters; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES)-1.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- button  input  1  raw push-button, asynchronous to clk, active-high
- btn_level  output  1  debounced button state
- btn_press  output  1  one-cycle pulse on an accepted press
- btn_release  output  1  one-cycle pulse on an accepted release
- btn_long  output  1  one-cycle pulse, at most once per press, after HOLD_CYCLES in PRESSED

Behaviour:
- Reset: rst_n low asynchronously clears the following, whether mid-press or mid-count:
  - synchronizer flops, both counters, hold_done, state=IDLE
  - all outputs to 0
- Synchronizer: 2 flops, button -> sync1 -> s. Only s is used downstream.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. The debounce counter dcnt is cleared on every state change.
- IDLE:
  - s=1 -> PRESS_WAIT.
- PRESS_WAIT:
  - s=0 -> IDLE. No output activity (bounce rejected).
  - s=1 and dcnt=DEBOUNCE_CYCLES-1 -> PRESSED. Clear hcnt and hold_done.
  - Otherwise dcnt++.
- PRESSED:
  - s=0 -> RELEASE_WAIT.
  - Otherwise, if hold_done=0: when hcnt=HOLD_CYCLES-1, set hold_done; else hcnt++.
- RELEASE_WAIT:
  - s=1 -> PRESSED. No pulse; hcnt and hold_done are kept.
  - s=0 and dcnt=DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise dcnt++. hcnt is frozen in this state.
- Outputs: all registered, with no combinational path from button.
  - btn_level=1 in PRESSED and RELEASE_WAIT, 0 otherwise.
  - btn_press is high for the single cycle after the PRESS_WAIT->PRESSED transition.
  - btn_release is high for the single cycle after the RELEASE_WAIT->IDLE transition.
  - btn_long is high for the single cycle after hold_done goes 0->1.
- Latency: with button stable high from edge k (first edge sampling it high):
  - state=PRESS_WAIT after edge k+2
  - PRESSED after edge k+2+DEBOUNCE_CYCLES
  - btn_press and btn_level rise together in that cycle
  - release latency is symmetric
- Bounce: any glitch shorter than DEBOUNCE_CYCLES restarts the qualification with no pulse. Each accepted press yields exactly one btn_press and, eventually, exactly one btn_release.
- Simultaneous events: btn_long and btn_release can never coincide, because hcnt is frozen in RELEASE_WAIT.
- Button held through reset deassertion: the press is detected normally, giving one btn_press D+2 edges after the first sampling edge.
- Counters never wrap: dcnt is bounded by the state transitions, and hcnt stops at HOLD_CYCLES-1.

Test Plan:
- Clean press (D=4, H=10): button rises and holds 30 cycles, then falls and stays low.
  - btn_press high exactly 1 cycle, 6 edges after the first sampling edge.
  - btn_level goes 1 in that same cycle.
  - btn_long pulses once, 10 cycles after entering PRESSED.
  - btn_release pulses once, 6 edges after the fall is first sampled.
  - btn_level goes 0 in the same cycle as btn_release.
- Bounce rejection (D=4): button toggles 1,0,1,0 with 2-cycle high/low phases, then stays low.
  - No pulses; btn_level stays 0; state returns to IDLE.
- Release bounce (D=4, H=10): pressed for 20 cycles, then a 2-cycle low glitch, then high again.
  - No btn_release; btn_level stays 1.
  - btn_long fires once only, with hcnt not restarted by the glitch.
- Short hold (D=4, H=10): press held 8 cycles past acceptance, then released.
  - btn_press and btn_release each fire once; btn_long never fires.
- Reset mid-press (D=4, H=10): rst_n pulled low 2 cycles after btn_press, button kept high.
  - All outputs go 0 immediately.
  - After rst_n rises, one new btn_press occurs 6 edges later; no spurious btn_release.
- Counter integration (D=4): 5 accepted presses drive the downstream 2-bit counter.
  - Counter sequence 01,10,11,00,01; exactly one increment per press.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, four-state debounce FSM and a
// one-shot long-press timer. All outputs are registered single-cycle events or a clean level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000,
  parameter int unsigned HOLD_CYCLES     = 32'd100000000,
  parameter int unsigned CNT_W           = 32'd27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] D_LAST   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HOLD_CYCLES - 32'd1);

  logic             r_sync1;
  logic             r_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] r_hcnt;
  logic             r_hold_done;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_long;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_dcnt_nxt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic             w_hold_nxt;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_long_nxt;

  // Bring the asynchronous pin into the clk domain; only r_sync is used beyond here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_sync1 <= button;
      r_sync  <= r_sync1;
    end
  end

  // Next-state, counter and event logic; dcnt restarts on every state change.
  always_comb begin
    w_state_nxt   = r_state;
    w_dcnt_nxt    = r_dcnt;
    w_hcnt_nxt    = r_hcnt;
    w_hold_nxt    = r_hold_done;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_dcnt_nxt = CNT_ZERO;
        if (r_sync) begin
          w_state_nxt = ST_PRESS_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!r_sync) begin
          w_state_nxt = ST_IDLE;
          w_dcnt_nxt  = CNT_ZERO;
        end else if (r_dcnt == D_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_dcnt_nxt  = CNT_ZERO;
          w_hcnt_nxt  = CNT_ZERO;
          w_hold_nxt  = 1'b0;
          w_press_nxt = 1'b1;
        end else begin
          w_dcnt_nxt  = r_dcnt + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!r_sync) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_dcnt_nxt  = CNT_ZERO;
        end else if (!r_hold_done) begin
          // The hold timer parks at its last value so it can never wrap.
          if (r_hcnt == H_LAST) begin
            w_hold_nxt = 1'b1;
            w_long_nxt = 1'b1;
          end else begin
            w_hcnt_nxt = r_hcnt + CNT_ONE;
          end
        end else begin
          w_hcnt_nxt = r_hcnt;
        end
      end
      ST_RELEASE_WAIT: begin
        if (r_sync) begin
          w_state_nxt = ST_PRESSED;
          w_dcnt_nxt  = CNT_ZERO;
        end else if (r_dcnt == D_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_dcnt_nxt    = CNT_ZERO;
          w_release_nxt = 1'b1;
        end else begin
          w_dcnt_nxt    = r_dcnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_dcnt_nxt  = CNT_ZERO;
        w_hcnt_nxt  = CNT_ZERO;
        w_hold_nxt  = 1'b0;
      end
    endcase
    w_level_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT);
  end

  // State, counters and registered outputs; the level follows the next state so it rises with btn_press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_dcnt      <= CNT_ZERO;
      r_hcnt      <= CNT_ZERO;
      r_hold_done <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_hcnt      <= w_hcnt_nxt;
      r_hold_done <= w_hold_nxt;
      r_level     <= w_level_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_long      <= w_long_nxt;
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_long    = r_long;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with D=4, H=10; expected edges are hand-derived
// from the first clock edge that samples each button change.
module tb_button_debounce;

  localparam int unsigned D = 32'd4;
  localparam int unsigned H = 32'd10;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic button = 1'b0;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .CNT_W          (32'd8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Pulse statistics, sampled on the falling edge.
  int   press_hi = 0, press_last = -1;
  int   rel_hi = 0, rel_last = -1;
  int   long_hi = 0, long_last = -1;
  int   rise_cnt = 0, rise_last = -1;
  int   fall_cnt = 0, fall_last = -1;
  int   lvl_hi = 0;
  logic lvl_prev = 1'b0;
  always @(negedge clk) begin
    if (btn_press)   begin press_hi <= press_hi + 1; press_last <= edge_n; end
    if (btn_release) begin rel_hi   <= rel_hi + 1;   rel_last   <= edge_n; end
    if (btn_long)    begin long_hi  <= long_hi + 1;  long_last  <= edge_n; end
    if (btn_level && !lvl_prev) begin rise_cnt <= rise_cnt + 1; rise_last <= edge_n; end
    if (!btn_level && lvl_prev) begin fall_cnt <= fall_cnt + 1; fall_last <= edge_n; end
    if (btn_level) lvl_hi <= lvl_hi + 1;
    lvl_prev <= btn_level;
  end

  // Downstream 2-bit press counter fed by btn_press.
  logic [1:0] ctr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr <= 2'd0;
    else if (btn_press) ctr <= ctr + 2'd1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int b_press, b_rel, b_long, b_fall, b_lvl;
  int k, kf, r;
  logic [1:0] exp_seq [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_press = press_hi; b_rel = rel_hi; b_long = long_hi; b_fall = fall_cnt; b_lvl = lvl_hi;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
    $fatal(1);
  end

  initial begin
    wait_n(3);
    check_eq("rst_level", btn_level, 0);
    check_eq("rst_press", btn_press, 0);
    check_eq("rst_release", btn_release, 0);
    check_eq("rst_long", btn_long, 0);
    rst_n = 1'b1;
    wait_n(3);

    // Clean press, 30 cycles high.
    snap(); button = 1'b1; k = edge_n + 1;
    wait_n(30);
    button = 1'b0; kf = edge_n + 1;
    wait_n(20);
    check_eq("clean_press_cnt", press_hi - b_press, 1);
    check_eq("clean_press_edge", press_last, k + 6);
    check_eq("clean_rise_edge", rise_last, k + 6);
    check_eq("clean_long_cnt", long_hi - b_long, 1);
    check_eq("clean_long_edge", long_last, k + 16);
    check_eq("clean_rel_cnt", rel_hi - b_rel, 1);
    check_eq("clean_rel_edge", rel_last, kf + 6);
    check_eq("clean_fall_edge", fall_last, kf + 6);

    // Bounce 1,0,1,0 with 2-cycle phases.
    snap();
    button = 1'b1; wait_n(2); button = 1'b0; wait_n(2);
    button = 1'b1; wait_n(2); button = 1'b0; wait_n(20);
    check_eq("bounce_press", press_hi - b_press, 0);
    check_eq("bounce_rel", rel_hi - b_rel, 0);
    check_eq("bounce_long", long_hi - b_long, 0);
    check_eq("bounce_level", lvl_hi - b_lvl, 0);

    // Release glitch after 20 cycles held.
    snap(); button = 1'b1; k = edge_n + 1;
    wait_n(20); button = 1'b0; wait_n(2); button = 1'b1; wait_n(20);
    check_eq("rglitch_rel", rel_hi - b_rel, 0);
    check_eq("rglitch_fall", fall_cnt - b_fall, 0);
    check_eq("rglitch_level", btn_level, 1);
    check_eq("rglitch_long_cnt", long_hi - b_long, 1);
    check_eq("rglitch_long_edge", long_last, k + 16);
    button = 1'b0; wait_n(20);
    check_eq("rglitch_final_rel", rel_hi - b_rel, 1);

    // Release glitch before the hold timer expires: hcnt resumes, not restarts.
    snap(); button = 1'b1; k = edge_n + 1;
    wait_n(10); button = 1'b0; wait_n(2); button = 1'b1; wait_n(20);
    check_eq("early_long_cnt", long_hi - b_long, 1);
    check_eq("early_long_edge", long_last, k + 19);
    check_eq("early_rel", rel_hi - b_rel, 0);
    check_eq("early_fall", fall_cnt - b_fall, 0);
    button = 1'b0; wait_n(20);
    check_eq("early_final_rel", rel_hi - b_rel, 1);

    // Short hold: released just before the hold timer would expire.
    snap(); button = 1'b1; k = edge_n + 1;
    wait_n(14); button = 1'b0; kf = edge_n + 1;
    wait_n(30);
    check_eq("short_press", press_hi - b_press, 1);
    check_eq("short_rel", rel_hi - b_rel, 1);
    check_eq("short_rel_edge", rel_last, kf + 6);
    check_eq("short_long", long_hi - b_long, 0);

    // Reset two cycles after btn_press with the button held.
    snap(); button = 1'b1; k = edge_n + 1;
    wait_n(9);
    check_eq("mid_press_before_rst", press_hi - b_press, 1);
    rst_n = 1'b0; #1;
    check_eq("mid_rst_level", btn_level, 0);
    check_eq("mid_rst_press", btn_press, 0);
    check_eq("mid_rst_release", btn_release, 0);
    check_eq("mid_rst_long", btn_long, 0);
    wait_n(2);
    snap(); rst_n = 1'b1; r = edge_n;
    wait_n(15);
    check_eq("post_rst_press", press_hi - b_press, 1);
    check_eq("post_rst_press_edge", press_last, r + 7);
    check_eq("post_rst_rel", rel_hi - b_rel, 0);
    check_eq("post_rst_level", btn_level, 1);
    button = 1'b0; wait_n(20);
    check_eq("post_rst_final_rel", rel_hi - b_rel, 1);

    // Five presses into the downstream 2-bit counter.
    rst_n = 1'b0; wait_n(1); rst_n = 1'b1; wait_n(2);
    check_eq("ctr_reset", ctr, 0);
    snap();
    for (int i = 0; i < 5; i++) begin
      button = 1'b1; wait_n(12);
      button = 1'b0; wait_n(12);
      check_eq($sformatf("ctr_step%0d", i), ctr, exp_seq[i]);
    end
    check_eq("ctr_press_total", press_hi - b_press, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
